// File: rtl/hex_digit_counter.sv
// Hex digit source: rate divider, 4-bit wrapping counter with parallel load, tick/carry strobes.
// Define DOWN_COUNT_EN to honour the down input (borrow on 0->F); otherwise up-only.
module hex_digit_counter #(
    parameter int CLK_FREQ = 50000000,
    parameter int DIV_W    = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic [1:0] rate_sel,
    input  logic       down,
    output logic [3:0] digit,
    output logic       tick,
    output logic       carry
);

    typedef enum logic [1:0] {
        RATE_EVERY = 2'b00,
        RATE_X1    = 2'b01,
        RATE_X2    = 2'b10,
        RATE_X4    = 2'b11
    } rate_e;

    localparam logic [DIV_W-1:0] RELOAD_X1 = DIV_W'(CLK_FREQ - 1);
    localparam logic [DIV_W-1:0] RELOAD_X2 = DIV_W'(2 * CLK_FREQ - 1);
    localparam logic [DIV_W-1:0] RELOAD_X4 = DIV_W'(4 * CLK_FREQ - 1);

    logic [DIV_W-1:0] r_rate_cnt;
    logic [1:0]       r_rate_sel_prev;
    logic [3:0]       r_digit;
    logic             r_tick;
    logic             r_carry;

    logic [DIV_W-1:0] w_reload;
    logic             w_rate_changed;
    logic             w_count_down;
    logic [3:0]       w_step_digit;
    logic             w_step_wrap;
    logic [DIV_W-1:0] w_rate_cnt_nxt;
    logic [3:0]       w_digit_nxt;
    logic             w_tick_nxt;
    logic             w_carry_nxt;

`ifdef DOWN_COUNT_EN
    assign w_count_down = down;
`else
    logic w_down_unused;
    assign w_down_unused = down;
    assign w_count_down  = 1'b0;
`endif

    always_comb begin
        w_reload = '0;
        case (rate_e'(rate_sel))
            RATE_EVERY: w_reload = '0;
            RATE_X1:    w_reload = RELOAD_X1;
            RATE_X2:    w_reload = RELOAD_X2;
            RATE_X4:    w_reload = RELOAD_X4;
            default:    w_reload = '0;
        endcase
    end

    assign w_rate_changed = (rate_sel != r_rate_sel_prev);

    // Borrow on 0->F when counting down, carry on F->0 when counting up.
    assign w_step_digit = w_count_down ? r_digit - 4'd1 : r_digit + 4'd1;
    assign w_step_wrap  = w_count_down ? (r_digit == 4'h0) : (r_digit == 4'hF);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_rate_cnt_nxt = r_rate_cnt;
        w_digit_nxt    = r_digit;
        w_tick_nxt     = 1'b0;
        w_carry_nxt    = 1'b0;
        if (load) begin
            w_digit_nxt    = load_value;
            w_rate_cnt_nxt = w_reload;
        end else if (w_rate_changed) begin
            w_rate_cnt_nxt = w_reload;
        end else if (enable) begin
            if (r_rate_cnt != '0) begin
                w_rate_cnt_nxt = r_rate_cnt - 1'b1;
            end else begin
                w_rate_cnt_nxt = w_reload;
                w_digit_nxt    = w_step_digit;
                w_tick_nxt     = 1'b1;
                w_carry_nxt    = w_step_wrap;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rate_cnt      <= '0;
            r_rate_sel_prev <= 2'b00;
            r_digit         <= 4'h0;
            r_tick          <= 1'b0;
            r_carry         <= 1'b0;
        end else begin
            r_rate_cnt      <= w_rate_cnt_nxt;
            r_rate_sel_prev <= rate_sel;
            r_digit         <= w_digit_nxt;
            r_tick          <= w_tick_nxt;
            r_carry         <= w_carry_nxt;
        end
    end

    assign digit = r_digit;
    assign tick  = r_tick;
    assign carry = r_carry;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed self-checking bench for hex_digit_counter with CLK_FREQ=4.
module tb_hex_digit_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [1:0] rate_sel;
    logic       down;
    logic [3:0] digit;
    logic       tick;
    logic       carry;

    int n_checks = 0;
    int n_pass   = 0;

    hex_digit_counter #(.CLK_FREQ(4), .DIV_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .load_value(load_value),
        .rate_sel  (rate_sel),
        .down      (down),
        .digit     (digit),
        .tick      (tick),
        .carry     (carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until tick is seen; n is the number of edges taken, -1 if the bound expired.
    task automatic wait_tick(input int max_edges, output int n);
        n = -1;
        for (int i = 1; i <= max_edges; i++) begin
            step();
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] exp_digit,
                              input logic exp_tick, input logic exp_carry);
        n_checks++;
        if ({digit, tick, carry} !== {exp_digit, exp_tick, exp_carry})
            $display("FAIL %s: got digit=%h tick=%b carry=%b, expected digit=%h tick=%b carry=%b",
                     name, digit, tick, carry, exp_digit, exp_tick, exp_carry);
        else
            n_pass++;
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = 4'h0;
        rate_sel = 2'b00; down = 1'b0;
        #1;
        expect_out("reset_state", 4'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_first_tick();
        enable = 1'b1;
        step();
        expect_out("first_enabled_edge_ticks", 4'h1, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        expect_out("disabled_hold", 4'h1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        load = 1'b1; load_value = 4'hE;
        step();
        expect_out("load_E", 4'hE, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1;
        step();
        expect_out("wrap_F", 4'hF, 1'b1, 1'b0);
        step();
        expect_out("wrap_0_carry", 4'h0, 1'b1, 1'b1);
        step();
        expect_out("wrap_1", 4'h1, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        expect_out("wrap_stop", 4'h1, 1'b0, 1'b0);
    endtask

    task automatic test_load_priority();
        enable = 1'b1; load = 1'b1; load_value = 4'hA;
        step();
        expect_out("load_over_count", 4'hA, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_value = 4'h7;
        step();
        load = 1'b0;
        expect_out("pre_reset_7", 4'h7, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        expect_out("async_reset_mid", 4'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_rate01();
        int n;
        rate_sel = 2'b01; enable = 1'b1;
        // Previous rate_sel resets to 00, so this edge is a speed change: reload, no tick.
        step();
        expect_out("rate01_change_edge", 4'h0, 1'b0, 1'b0);
        wait_tick(20, n);
        expect_int("rate01_first_spacing", n, 4);
        expect_out("rate01_digit1", 4'h1, 1'b1, 1'b0);
        step();
        expect_out("rate01_tick_one_cycle", 4'h1, 1'b0, 1'b0);
        wait_tick(20, n);
        expect_int("rate01_spacing2", n, 3);
        wait_tick(20, n);
        expect_int("rate01_spacing3", n, 4);
        expect_out("rate01_digit3", 4'h3, 1'b1, 1'b0);
    endtask

    task automatic test_rate_switch();
        int n;
        step();
        rate_sel = 2'b11;
        step();
        expect_out("switch_no_tick", 4'h3, 1'b0, 1'b0);
        wait_tick(40, n);
        expect_int("switch_spacing16", n, 16);
        expect_out("switch_digit4", 4'h4, 1'b1, 1'b0);
    endtask

    task automatic test_enable_hold();
        int n;
        int ticks_seen;
        rate_sel = 2'b10;
        step();
        expect_out("rate10_change_edge", 4'h4, 1'b0, 1'b0);
        wait_tick(20, n);
        expect_int("rate10_spacing8", n, 8);
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tick === 1'b1) ticks_seen++;
        end
        expect_int("disabled_no_ticks", ticks_seen, 0);
        expect_out("disabled_digit_held", 4'h5, 1'b0, 1'b0);
        enable = 1'b1;
        wait_tick(20, n);
        expect_int("stretched_remainder", n, 5);
        expect_out("stretched_digit6", 4'h6, 1'b1, 1'b0);
        wait_tick(20, n);
        expect_int("rate10_spacing_after", n, 8);
    endtask

    task automatic test_direction();
        enable = 1'b0; rate_sel = 2'b00;
        step();
        load = 1'b1; load_value = 4'h1;
        step();
        expect_out("dir_load_1", 4'h1, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b1; down = 1'b1;
`ifdef DOWN_COUNT_EN
        step();
        expect_out("down_0", 4'h0, 1'b1, 1'b0);
        step();
        expect_out("down_F_borrow", 4'hF, 1'b1, 1'b1);
        step();
        expect_out("down_E", 4'hE, 1'b1, 1'b0);
`else
        step();
        expect_out("up_only_2", 4'h2, 1'b1, 1'b0);
        step();
        expect_out("up_only_3", 4'h3, 1'b1, 1'b0);
        step();
        expect_out("up_only_4", 4'h4, 1'b1, 1'b0);
`endif
        enable = 1'b0; down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_wrap();
        test_load_priority();
        test_reset_mid();
        test_rate01();
        test_rate_switch();
        test_enable_hold();
        test_direction();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
